// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counter timer on the core's data-memory port.
// Eight-word register window at BASE_ADDR. Writes land on the clock edge and
// reads are combinational, so the block behaves exactly like dmem to the core.
// Optional build macro MMIO_TIMER_IRQ_EN adds the CTRL.IE bit and a registered
// irq output. Without it, irq is tied low and CTRL[2] is absent.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned PS_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PS     = 3'd4;

  logic [2:0]      off;
  logic            wr_ctrl;
  logic            wr_load;
  logic            wr_count;
  logic            wr_status;
  logic            wr_ps;
  logic            en;
  logic            ar;
  logic            ie;
  logic [31:0]     load;
  logic [31:0]     count;
  logic            exp_flag;
  logic [PS_W-1:0] prescale;
  logic [PS_W-1:0] pcnt;
  logic            tick;
  logic            expire;
  logic            unused_adr;

  // Byte-lane bits carry no meaning for word registers.
  assign unused_adr = ^dataadr[1:0];

  assign sel       = (dataadr[31:5] == BASE_ADDR[31:5]);
  assign off       = dataadr[4:2];
  assign wr_ctrl   = memwrite && sel && (off == OFF_CTRL);
  assign wr_load   = memwrite && sel && (off == OFF_LOAD);
  assign wr_count  = memwrite && sel && (off == OFF_COUNT);
  assign wr_status = memwrite && sel && (off == OFF_STATUS);
  assign wr_ps     = memwrite && sel && (off == OFF_PS);

  // A tick fires on the cycle the prescaler reaches PRESCALE; expiry is a
  // tick that finds the counter already at zero.
  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count == 32'd0);

  // Prescaler: restarts whenever the timebase is disturbed or a tick fires.
  always_ff @(posedge clk) begin
    if (reset || !en || wr_count || wr_ps || tick) pcnt <= '0;
    else                                          pcnt <= pcnt + PS_W'(1);
  end

  // Counter: software write wins over the tick update; never wraps below 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= writedata;
    end else if (tick) begin
      if (count != 32'd0) count <= count - 32'd1;
      else if (ar)        count <= load;
    end
  end

  // EN/AR: a CTRL write wins over the one-shot self-disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      en <= 1'b0;
      ar <= 1'b0;
    end else if (wr_ctrl) begin
      en <= writedata[0];
      ar <= writedata[1];
    end else if (expire && !ar) begin
      en <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  // Interrupt enable bit.
  always_ff @(posedge clk) begin
    if (reset)        ie <= 1'b0;
    else if (wr_ctrl) ie <= writedata[2];
  end

  // Registered interrupt: follows EXP & IE one cycle later.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= exp_flag & ie;
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // LOAD and PRESCALE are plain software-written registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      load     <= 32'd0;
      prescale <= '0;
    end else begin
      if (wr_load) load     <= writedata;
      if (wr_ps)   prescale <= writedata[PS_W-1:0];
    end
  end

  // Sticky EXP: an expiry on the same edge beats a write-one-to-clear.
  always_ff @(posedge clk) begin
    if (reset)                        exp_flag <= 1'b0;
    else if (expire)                  exp_flag <= 1'b1;
    else if (wr_status && writedata[0]) exp_flag <= 1'b0;
  end

  // Combinational read mux; unselected or unused offsets read as zero.
  always_comb begin
    readdata = 32'd0;
    if (sel) begin
      case (off)
        OFF_CTRL:   readdata[2:0]      = {ie, ar, en};
        OFF_LOAD:   readdata           = load;
        OFF_COUNT:  readdata           = count;
        OFF_STATUS: readdata[0]        = exp_flag;
        OFF_PS:     readdata[PS_W-1:0] = prescale;
        default:    readdata           = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scenarios plus randomized register traffic for
// mmio_timer, compared against a cycle-level behavioural model of the timer.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef MMIO_TIMER_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
  localparam bit         IRQ_ON    = 1'b1;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
  localparam bit         IRQ_ON    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel;
  logic        irq;

  always #5 clk = ~clk;

  mmio_timer #(.BASE_ADDR(BASE), .PS_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .sel       (sel),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Behavioural model state
  logic [2:0]  m_ctrl  = '0;
  logic [31:0] m_load  = '0;
  logic [31:0] m_count = '0;
  logic        m_exp   = 1'b0;
  logic [15:0] m_ps    = '0;
  logic [15:0] m_pcnt  = '0;
  logic        m_irq   = 1'b0;

  function automatic bit m_sel(input logic [31:0] a);
    return (a >> 5) == (BASE >> 5);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_sel(a)) return 32'd0;
    case ((a >> 2) & 32'd7)
      32'd0:   return {29'd0, m_ctrl};
      32'd1:   return m_load;
      32'd2:   return m_count;
      32'd3:   return {31'd0, m_exp};
      32'd4:   return {16'd0, m_ps};
      default: return 32'd0;
    endcase
  endfunction

  // Advance model and DUT by one clock edge using the currently driven inputs.
  task automatic do_cycle();
    logic [2:0]  n_ctrl;
    logic [31:0] n_load, n_count;
    logic        n_exp, n_irq;
    logic [15:0] n_ps, n_pcnt;
    logic [31:0] o;
    bit          w, tk, ex;
    n_ctrl = m_ctrl; n_load = m_load; n_count = m_count;
    n_exp = m_exp; n_ps = m_ps; n_pcnt = m_pcnt; n_irq = m_irq;
    o  = (dataadr >> 2) & 32'd7;
    w  = memwrite && m_sel(dataadr);
    if (reset) begin
      n_ctrl = '0; n_load = '0; n_count = '0; n_exp = 0; n_ps = '0; n_pcnt = '0; n_irq = 0;
    end else begin
      tk = m_ctrl[0] && (m_pcnt == m_ps);
      ex = tk && (m_count == 0);
      if (tk) n_count = (m_count == 0) ? (m_ctrl[1] ? m_load : 32'd0) : m_count - 1;
      if (w && o == 2) n_count = writedata;
      if (!m_ctrl[0] || (w && (o == 2 || o == 4)) || tk) n_pcnt = 0;
      else n_pcnt = m_pcnt + 1;
      if (ex && !m_ctrl[1]) n_ctrl[0] = 0;
      if (w && o == 0) n_ctrl = writedata[2:0] & CTRL_MASK;
      if (w && o == 1) n_load = writedata;
      if (w && o == 4) n_ps = writedata[15:0];
      if (w && o == 3 && writedata[0]) n_exp = 0;
      if (ex) n_exp = 1;
      n_irq = IRQ_ON && m_exp && m_ctrl[2];
    end
    @(posedge clk);
    #1;
    m_ctrl = n_ctrl; m_load = n_load; m_count = n_count; m_exp = n_exp;
    m_ps = n_ps; m_pcnt = n_pcnt; m_irq = n_irq;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    do_cycle();
    memwrite = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    memwrite = 1'b0; dataadr = a;
    #1;
    v = readdata;
  endtask

  logic [31:0] v;
  int          n;

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = BASE; writedata = '0;
    do_cycle(); do_cycle();
    reset = 1'b0;

    // Reset state and decode
    for (int i = 0; i < 8; i++) begin
      peek(BASE + 32'(4 * i), v);
      check($sformatf("rst_rd%0d", i), v, 32'd0);
    end
    check("rst_sel", sel, 1'b1);
    do_cycle();
    check("rst_irq", irq, 1'b0);
    peek(32'h3FC, v);
    check("below_sel", sel, 1'b0);
    check("below_rd", v, 32'd0);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      peek(BASE + 32'(4 * i), v);
      check($sformatf("off5_wr%0d", i), v, 32'd0);
    end

    // One-shot countdown
    wr(BASE + 32'h08, 32'd3);
    wr(BASE + 32'h10, 32'd0);
    wr(BASE + 32'h00, 32'd1);
    for (int k = 3; k >= 0; k--) begin
      peek(BASE + 32'h08, v);
      check($sformatf("os_count%0d", k), v, 32'(k));
      peek(BASE + 32'h0C, v);
      check("os_exp_pending", v, 32'd0);
      do_cycle();
    end
    peek(BASE + 32'h0C, v);
    check("os_exp_set", v, 32'd1);
    peek(BASE + 32'h00, v);
    check("os_en_clear", v, 32'd0);
    do_cycle(); do_cycle();
    peek(BASE + 32'h08, v);
    check("os_count_hold", v, 32'd0);

    // Auto-reload with prescale 1: period (2+1)*(1+1) = 6
    wr(BASE + 32'h0C, 32'd1);
    wr(BASE + 32'h04, 32'd2);
    wr(BASE + 32'h08, 32'd2);
    wr(BASE + 32'h10, 32'd1);
    wr(BASE + 32'h00, 32'd3);
    n = 0;
    do begin
      do_cycle(); n++;
      peek(BASE + 32'h0C, v);
    end while (v == 0 && n < 20);
    check("ar_first", 32'(n), 32'd6);
    wr(BASE + 32'h0C, 32'd1);
    n = 1;
    peek(BASE + 32'h0C, v);
    check("ar_w1c", v, 32'd0);
    do begin
      do_cycle(); n++;
      peek(BASE + 32'h0C, v);
    end while (v == 0 && n < 20);
    check("ar_period", 32'(n), 32'd6);

    // IRQ behaviour (or its absence)
    wr(BASE + 32'h0C, 32'd1);
    wr(BASE + 32'h00, 32'd7);
    peek(BASE + 32'h00, v);
    check("ctrl_rb", v, {29'd0, CTRL_MASK});
    n = 0;
    do begin
      check("irq_low", irq, 1'b0);
      do_cycle(); n++;
      peek(BASE + 32'h0C, v);
    end while (v == 0 && n < 20);
    check("irq_exp_seen", v, 32'd1);
    check("irq_lag", irq, 1'b0);
    do_cycle();
    check("irq_rise", irq, 32'(IRQ_ON));
    wr(BASE + 32'h0C, 32'd1);
    check("irq_hold", irq, 32'(IRQ_ON));
    do_cycle();
    check("irq_fall", irq, 1'b0);

    // Collisions
    wr(BASE + 32'h10, 32'd0);
    wr(BASE + 32'h08, 32'd10);
    peek(BASE + 32'h08, v);
    check("coll_count", v, 32'd10);
    do_cycle();
    peek(BASE + 32'h08, v);
    check("coll_count_next", v, 32'd9);
    wr(BASE + 32'h08, 32'd5);
    wr(BASE + 32'h0C, 32'd1);
    peek(BASE + 32'h0C, v);
    check("coll_pre_clear", v, 32'd0);
    wr(BASE + 32'h08, 32'd0);
    wr(BASE + 32'h0C, 32'd1);
    peek(BASE + 32'h0C, v);
    check("coll_w1c", v, 32'd1);
    peek(BASE + 32'h08, v);
    check("coll_reload", v, 32'd2);

    // Mid-run reset
    wr(BASE + 32'h10, 32'd0);
    wr(BASE + 32'h00, 32'd1);
    wr(BASE + 32'h08, 32'd5);
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      peek(BASE + 32'(4 * i), v);
      check($sformatf("mr_rd%0d", i), v, 32'd0);
    end
    check("mr_irq", irq, 1'b0);
    repeat (8) do_cycle();
    peek(BASE + 32'h08, v);
    check("mr_count_idle", v, 32'd0);
    peek(BASE + 32'h0C, v);
    check("mr_exp_idle", v, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] a, d;
      int unsigned o;
      o = $urandom_range(0, 7);
      a = BASE + 32'(4 * o) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      case (o)
        1, 2:    d = 32'($urandom_range(0, 6));
        4:       d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      reset     = ($urandom_range(0, 299) == 0);
      memwrite  = ($urandom_range(0, 3) == 0);
      dataadr   = a;
      writedata = d;
      #1;
      check("rnd_rd", readdata, m_read(a));
      check("rnd_sel", sel, 32'(m_sel(a)));
      check("rnd_irq", irq, m_irq);
      do_cycle();
    end
    reset = 1'b0;
    memwrite = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counter timer that acts as a responder on the single-cycle core's data-memory port (memwrite/dataadr/writedata/readdata). It decodes an 8-word window and accepts register writes on the clock edge, exactly as data memory does. It returns register contents combinationally on readdata. The top level muxes its readdata in place of dmem's whenever sel is high.

## Interface
- BASE_ADDR, 32'h0000_0400, byte base of the 8-word register window (bits [4:0] ignored)
- PS_W, 16, prescaler width
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- memwrite  input  1  store strobe from the core
- dataadr  input  32  byte address from the core
- writedata  input  32  store data
- readdata  output  32  load data; 0 when not selected
- sel  output  1  dataadr[31:5] == BASE_ADDR[31:5]
- irq  output  1  interrupt request (see Configuration)

## Operation
- Decode: word offset = dataadr[4:2]; dataadr[1:0] ignored. Offsets 5–7 read 0; writes to them are ignored. A write occurs only when memwrite and sel are both high.
- Registers:
  - 0x00 CTRL: [0] EN, [1] AR (auto-reload), [2] IE; other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: read returns the live counter; write sets the counter.
  - 0x0C STATUS: [0] EXP, sticky; writing 1 to bit 0 clears it, writing 0 has no effect.
  - 0x10 PRESCALE: PS_W bits, zero-extended on read.
- Prescaler `pcnt`:
  - Cleared while EN=0, and on any write to COUNT or PRESCALE.
  - When EN=1: if pcnt == PRESCALE, assert `tick` for that cycle and set pcnt to 0; otherwise increment pcnt.
- Counter, evaluated on each tick:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: EXP is set. If AR=1, COUNT loads LOAD. If AR=0 (one-shot), EN clears and COUNT stays 0.
- Same-cycle priority:
  - A write to COUNT overrides any tick update.
  - A CTRL write overrides the one-shot EN clear.
  - An EXP set overrides a same-cycle W1C clear.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- Reset values: CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, pcnt=0. Outputs after reset: readdata=0, irq=0. sel depends only on dataadr.
- Writes take effect at the posedge on which memwrite is sampled high. A read in the following cycle returns the new value.
- readdata is purely combinational from dataadr and the register state. It has zero-cycle latency, matching dmem.
- With PRESCALE=P, ticks occur every P+1 cycles while EN=1. The first tick comes P+1 cycles after the edge that sets EN.
- With LOAD=N and AR=1, EXP sets every (N+1)·(P+1) cycles.
- Reset asserted mid-count returns every register to its reset value on that edge. No tick is processed on that edge.

## Configuration
- MMIO_TIMER_IRQ_EN defined:
  - irq = STATUS.EXP & CTRL.IE, registered, so it changes one cycle after EXP changes.
  - CTRL[2] is writable.
- MMIO_TIMER_IRQ_EN undefined:
  - irq is tied to 0.
  - CTRL[2] is not implemented; it reads 0 and ignores writes.
  - All other behaviour is identical.

## Test plan
- Reset/decode:
  - After reset, a read at 0x400..0x41C returns 0 with sel=1.
  - dataadr=0x3FC gives sel=0 and readdata=0.
  - A write at 0x414 changes no register.
- One-shot:
  - Sequence: LOAD is not used; write COUNT=3, PRESCALE=0, CTRL=0x1.
  - COUNT reads 3,2,1,0 on successive cycles. EXP sets 4 cycles after the CTRL write edge.
  - EN then reads 0 and COUNT holds at 0.
- Auto-reload with prescale: LOAD=2, COUNT=2, PRESCALE=1, CTRL=0x3 → EXP period is 6 cycles. Clear EXP by writing 1 to 0x40C and confirm it sets again 6 cycles later.
- Collisions:
  - A COUNT write of 10 on the same edge as a tick makes COUNT read 10.
  - A W1C of STATUS on the same edge as an expiry leaves EXP=1.
- IRQ:
  - With the macro defined and CTRL=0x7, irq rises one cycle after EXP and falls one cycle after the W1C.
  - With the macro undefined, irq stays 0 and a CTRL write of 0x7 reads back as 0x3.
- Mid-run reset: assert reset for 1 cycle with COUNT=5 and EN=1. All registers read 0 afterwards and no further ticks occur.
